uncache_rdata_buf: RTL and testbench
====================================

// Module: uncache_rdata_buf
// PURPOSE
//   Parametrised uncached-load return buffer for the data-memory path. Registers read data
//   returning from dsram/bus for uncached loads, aligns and sign/zero-extends it by byte
//   offset and size, and queues results in a DEPTH-entry FIFO drained by a valid/ready
//   consumer. Cached loads bypass this block entirely; its output is zero when not valid.
// PARAMETERS
//   DATA_W  64  return data width; 32 or 64
//   DEPTH   4   FIFO entries; power of 2, >= 2
//   OFF_W   derived = $clog2(DATA_W/8); byte-offset width (3 for 64, 2 for 32)
// PORTS
//   clk         in   1        clock, rising edge
//   rst         in   1        reset, asynchronous, active-high
//   in_valid    in   1        return beat present on in_rdata
//   in_uncache  in   1        beat belongs to an uncached load; ignored when 0
//   in_ready    out  1        buffer can accept an uncached beat this cycle
//   in_rdata    in   DATA_W   raw read data, lane 0 = bits [7:0]
//   in_offset   in   OFF_W    byte offset of load within the word
//   in_size     in   2        0=byte 1=half 2=word 3=dword
//   in_signed   in   1        1=sign-extend, 0=zero-extend
//   flush       in   1        synchronous discard of all buffered state
//   out_valid   out  1        aligned result at FIFO head
//   out_ready   in   1        consumer takes head this cycle
//   out_rdata   out  DATA_W   aligned, extended result; 0 when out_valid=0
//   drop_err    out  1        sticky: uncached beat arrived while in_ready=0
//   count       out  $clog2(DEPTH+1)  entries in FIFO (excludes capture stage)
// BEHAVIOUR
//   Reset (async): s1_valid=0, FIFO empty, count=0, out_valid=0, out_rdata=0, drop_err=0,
//     in_ready=1. Pointers return to 0.
//   Accept: acc = in_valid & in_uncache & in_ready. in_valid & ~in_uncache has no effect.
//   Stage 1 (capture reg): on acc, latch rdata/offset/size/signed, s1_valid<=1; else s1_valid<=0.
//   Stage 2: when s1_valid, aligned value written to FIFO tail on next edge.
//   Latency: accept at edge E0 -> out_valid=1 after E1 if FIFO was empty (2-cycle load-to-use).
//   in_ready = (count + s1_valid) < DEPTH, from registers only; a same-cycle pop is NOT
//     credited (conservative, no comb path out_ready->in_ready).
//   Pop: out_valid & out_ready advances head; push and pop same cycle keep count unchanged.
//   Align: sh = in_rdata >> (offset*8), logical (zero fill). Keep low 8/16/32/64 bits per size;
//     extend with MSB of kept field if signed, else zeros. DATA_W=32: size 3 treated as 2.
//     Misaligned offset+size is not checked; result uses zero-filled upper lanes.
//   Pointers wrap modulo DEPTH; count never exceeds DEPTH, never underflows.
//   drop_err: set when in_valid & in_uncache & ~in_ready; holds until flush or rst.
//   flush: next edge s1_valid=0, FIFO empty, count=0, drop_err=0; overrides same-cycle accept,
//     push and pop (flushed beat is discarded, not flagged as drop).
//   out_rdata forced to 0 whenever out_valid=0.
// TESTING
//   1. DATA_W=64: in_rdata=64'h8877_6655_4433_2211, offset=4, size=1, signed=1 -> after 2 edges
//      out_valid=1, out_rdata=64'h0000_0000_0000_6655; same with offset=7,size=0 -> 64'hFFFF_FFFF_FFFF_FF88.
//   2. Cached beat: in_valid=1, in_uncache=0 for 10 cycles -> out_valid=0, out_rdata=0, count=0.
//   3. out_ready=0, push 5 beats back-to-back (DEPTH=4) -> count=4, in_ready=0 after 3rd accept
//      edge+1, 5th+ beat sets drop_err=1; then drain -> 4 results in order, values intact.
//   4. Full FIFO, out_ready=1 and new beat each cycle -> in_ready tracks count+s1_valid,
//      no entry lost or duplicated over 20 beats with incrementing data (scoreboard).
//   5. flush asserted same cycle as accept and pop with 3 entries -> next cycle count=0,
//      out_valid=0, drop_err=0, flushed beat never appears at output.
//   6. rst asserted asynchronously mid-burst (between edges) -> out_valid, out_rdata, count
//      drop to 0 immediately, in_ready=1; normal operation resumes after rst release.

Source files
------------

// File: rtl/uncache_rdata_buf.sv
// Uncached-load return buffer: capture stage, byte alignment / extension,
// and a DEPTH-entry FIFO drained by a valid/ready consumer.
module uncache_rdata_buf #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned OFF_W = $clog2(DATA_W / 8),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_uncache,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rdata,
    input  logic [OFF_W-1:0]  in_offset,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic              drop_err,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_rdata_q;
    logic [OFF_W-1:0]  s1_offset_q;
    logic [1:0]        s1_size_q;
    logic              s1_signed_q;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              drop_q;

    logic [CNT_W:0]    occ_c;
    logic              acc_c;
    logic              push_c;
    logic              pop_c;
    logic [DATA_W-1:0] shifted_c;
    logic [DATA_W-1:0] aligned_c;

    // Occupancy counts the capture stage too; a same-cycle pop is not credited.
    assign occ_c     = (CNT_W + 1)'(count_q) + (CNT_W + 1)'(s1_valid_q);
    assign in_ready  = occ_c < (CNT_W + 1)'(DEPTH);
    assign acc_c     = in_valid & in_uncache & in_ready;
    assign push_c    = s1_valid_q;
    assign out_valid = (count_q != '0);
    assign pop_c     = out_valid & out_ready;
    assign out_rdata = out_valid ? mem_q[rd_ptr_q] : '0;
    assign drop_err  = drop_q;
    assign count     = count_q;

    // Capture stage: hold one accepted beat for alignment on the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_rdata_q  <= '0;
            s1_offset_q <= '0;
            s1_size_q   <= 2'd0;
            s1_signed_q <= 1'b0;
        end else if (flush) begin
            s1_valid_q  <= 1'b0;
        end else begin
            s1_valid_q  <= acc_c;
            if (acc_c) begin
                s1_rdata_q  <= in_rdata;
                s1_offset_q <= in_offset;
                s1_size_q   <= in_size;
                s1_signed_q <= in_signed;
            end
        end
    end

    // Shift the addressed bytes to lane 0 and extend from the field width.
    always_comb begin
        shifted_c = s1_rdata_q >> {s1_offset_q, 3'b000};
        aligned_c = shifted_c;
        case (s1_size_q)
            2'd0: begin
                if (s1_signed_q) aligned_c = DATA_W'($signed(shifted_c[7:0]));
                else             aligned_c = DATA_W'(shifted_c[7:0]);
            end
            2'd1: begin
                if (s1_signed_q) aligned_c = DATA_W'($signed(shifted_c[15:0]));
                else             aligned_c = DATA_W'(shifted_c[15:0]);
            end
            2'd2: begin
                if (s1_signed_q) aligned_c = DATA_W'($signed(shifted_c[31:0]));
                else             aligned_c = DATA_W'(shifted_c[31:0]);
            end
            default: aligned_c = shifted_c;
        endcase
    end

    // FIFO storage; contents are masked at the output so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_c && !flush) begin
            mem_q[wr_ptr_q] <= aligned_c;
        end
    end

    // FIFO pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky flag for uncached beats offered while the buffer was full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= 1'b0;
        end else if (flush) begin
            drop_q <= 1'b0;
        end else if (in_valid && in_uncache && !in_ready) begin
            drop_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uncache_rdata_buf.sv
// Directed bench for uncache_rdata_buf with a queue-based reference model.
module tb_uncache_rdata_buf;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned OFF_W  = 3;
    localparam int unsigned CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_uncache = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_rdata = '0;
    logic [OFF_W-1:0]  in_offset = '0;
    logic [1:0]        in_size = 2'd0;
    logic              in_signed = 1'b0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_rdata;
    logic              drop_err;
    logic [CNT_W-1:0]  count;

    uncache_rdata_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_uncache(in_uncache), .in_ready(in_ready),
        .in_rdata(in_rdata), .in_offset(in_offset), .in_size(in_size),
        .in_signed(in_signed), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .drop_err(drop_err), .count(count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: queued results, one pending captured beat, sticky drop.
    logic [63:0] exp_q[$];
    bit          s1_pend = 1'b0;
    logic [63:0] s1_val  = '0;
    bit          m_drop  = 1'b0;

    bit          sb_en = 1'b0;
    logic [63:0] sent_q[$];
    logic [63:0] got_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] model_align(input logic [63:0] d, input int off,
                                                input int sz, input bit sgn);
        int          nbits = 8 << sz;
        logic [63:0] v     = d >> (off * 8);
        logic [63:0] mask;
        if (nbits >= 64) return v;
        mask = (64'd1 << nbits) - 64'd1;
        v    = v & mask;
        if (sgn && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit model_ready();
        return (exp_q.size() + int'(s1_pend)) < DEPTH;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        s1_pend = 1'b0;
        m_drop  = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_step();
        bit rdy;
        bit acc;
        bit pop;
        if (rst || flush) begin
            model_reset();
            return;
        end
        rdy = model_ready();
        acc = in_valid && in_uncache && rdy;
        pop = (exp_q.size() > 0) && out_ready;
        if (in_valid && in_uncache && !rdy) m_drop = 1'b1;
        if (pop) void'(exp_q.pop_front());
        if (s1_pend) exp_q.push_back(s1_val);
        s1_pend = acc;
        if (acc) begin
            s1_val = model_align(in_rdata, int'(in_offset), int'(in_size), in_signed);
            if (sb_en) sent_q.push_back(s1_val);
        end
    endtask

    task automatic cycle();
        if (sb_en && out_valid && out_ready) got_q.push_back(out_rdata);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic beat(input logic [63:0] d, input int off, input int sz, input bit sgn);
        in_valid   = 1'b1;
        in_uncache = 1'b1;
        in_rdata   = d;
        in_offset  = OFF_W'(off);
        in_size    = 2'(sz);
        in_signed  = sgn;
        cycle();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        chk("out_rdata", out_rdata, (exp_q.size() != 0) ? exp_q[0] : 64'd0);
        chk("count", 64'(count), 64'(exp_q.size()));
        chk("in_ready", 64'(in_ready), 64'(model_ready()));
        chk("drop_err", 64'(drop_err), 64'(m_drop));
    end

    initial begin
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        rst = 1'b0;
        idle(1);

        // Alignment: signed half at offset 4, signed byte at offset 7.
        out_ready = 1'b0;
        beat(64'h8877_6655_4433_2211, 4, 1, 1'b1);
        idle(1);
        chk("t1_half_valid", 64'(out_valid), 64'd1);
        chk("t1_half_data", out_rdata, 64'h0000_0000_0000_6655);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        beat(64'h8877_6655_4433_2211, 7, 0, 1'b1);
        idle(1);
        chk("t1_byte_data", out_rdata, 64'hFFFF_FFFF_FFFF_FF88);
        out_ready = 1'b1;
        idle(1);

        // Assorted offset/size/sign combinations streamed through.
        for (int i = 0; i < 12; i++) begin
            beat(64'hF1E2_D3C4_B5A6_9788 + 64'(i * 64'h0101_0101), (i * 3) % 8, i % 4, i[0]);
        end
        idle(3);
        chk("t1_drained", 64'(count), 64'd0);

        // Cached beats are ignored.
        in_valid   = 1'b1;
        in_uncache = 1'b0;
        in_rdata   = 64'hDEAD_BEEF_0000_0001;
        repeat (10) cycle();
        chk("t2_valid", 64'(out_valid), 64'd0);
        chk("t2_rdata", out_rdata, 64'd0);
        chk("t2_count", 64'(count), 64'd0);

        // Overfill with the consumer stalled, then drain in order.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) beat(64'h1000 + 64'(i), 0, 3, 1'b0);
        idle(2);
        chk("t3_count_full", 64'(count), 64'd4);
        chk("t3_ready_low", 64'(in_ready), 64'd0);
        chk("t3_drop", 64'(drop_err), 64'd1);
        chk("t3_head", out_rdata, 64'h1000);
        out_ready = 1'b1;
        idle(6);
        chk("t3_empty", 64'(count), 64'd0);

        // Full FIFO with continuous pops and offers; scoreboard the flow.
        sent_q.delete();
        got_q.delete();
        sb_en     = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(64'h2000 + 64'(i), 0, 3, 1'b0);
        idle(2);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) beat(64'h3000 + 64'(i), 0, 3, 1'b0);
        idle(8);
        sb_en = 1'b0;
        chk("t4_sb_size", 64'(got_q.size()), 64'(sent_q.size()));
        chk("t4_sb_min", 64'(got_q.size() >= 8), 64'd1);
        for (int i = 0; i < sent_q.size() && i < got_q.size(); i++) begin
            chk("t4_sb_entry", got_q[i], sent_q[i]);
        end

        // Flush colliding with accept and pop while holding three entries.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) beat(64'h4000 + 64'(i), 0, 3, 1'b0);
        idle(2);
        chk("t5_count3", 64'(count), 64'd3);
        chk("t5_drop_pre", 64'(drop_err), 64'd1);
        out_ready = 1'b1;
        flush     = 1'b1;
        beat(64'h5555, 0, 3, 1'b0);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t5_count0", 64'(count), 64'd0);
        chk("t5_valid0", 64'(out_valid), 64'd0);
        chk("t5_drop0", 64'(drop_err), 64'd0);
        idle(3);
        chk("t5_no_ghost", 64'(out_valid), 64'd0);

        // Asynchronous reset between edges mid-burst.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) beat(64'h6000 + 64'(i), 0, 3, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_rdata", out_rdata, 64'd0);
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        cycle();
        rst = 1'b0;
        idle(1);
        beat(64'h0000_0000_8000_0000, 0, 2, 1'b1);
        idle(1);
        chk("t6_resume", out_rdata, 64'hFFFF_FFFF_8000_0000);
        out_ready = 1'b1;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
